// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access path: sequencer state encoding,
// default widths and register addresses used by the time-keeping logic.
package rtc_pkg;
  localparam int RTC_ADDR_W = 8;
  localparam int RTC_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACTIVE,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [7:0] RTC_REG_SEC   = 8'h00;
  localparam logic [7:0] RTC_REG_MIN   = 8'h02;
  localparam logic [7:0] RTC_REG_HOUR  = 8'h04;
  localparam logic [7:0] RTC_REG_DAY   = 8'h07;
  localparam logic [7:0] RTC_REG_MONTH = 8'h08;
  localparam logic [7:0] RTC_REG_YEAR  = 8'h09;
  localparam logic [7:0] RTC_REG_A     = 8'h0A;
  localparam logic [7:0] RTC_REG_B     = 8'h0B;
  localparam logic [7:0] RTC_REG_C     = 8'h0C;
endpackage

// File: rtl/rtc_access_sequencer_if.sv
// FSM_W_R handshake plus multiplexed A/D pad bus between sequencer (master)
// and the bus-cycle FSM / pad ring (slave).
interface rtc_access_sequencer_if #(
  parameter int ADDR_W = rtc_pkg::RTC_ADDR_W
);
  logic              fsm_do_it;
  logic              fsm_w_r;
  logic              fsm_cs;
  logic              fsm_send_add;
  logic              fsm_send_data;
  logic              fsm_read_data;
  logic [ADDR_W-1:0] ad_in;
  logic [ADDR_W-1:0] ad_out;
  logic              ad_oe;

  modport master (
    output fsm_do_it, fsm_w_r, ad_out, ad_oe,
    input  fsm_cs, fsm_send_add, fsm_send_data, fsm_read_data, ad_in
  );

  modport slave (
    input  fsm_do_it, fsm_w_r, ad_out, ad_oe,
    output fsm_cs, fsm_send_add, fsm_send_data, fsm_read_data, ad_in
  );
endinterface

// File: rtl/rtc_ad_bus_mux.sv
// A/D pad mux (address has priority over data) and single-shot read-byte
// capture on the first cycle of read_data within a transaction.
module rtc_ad_bus_mux
  import rtc_pkg::*;
#(
  parameter int ADDR_W = RTC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] wbyte,
  input  logic              wr_mode,
  input  logic              send_add,
  input  logic              send_data,
  input  logic              read_data,
  input  logic              cs,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] ad_in,
  output logic [ADDR_W-1:0] ad_out,
  output logic              ad_oe,
  output logic [ADDR_W-1:0] rdata,
  output logic              rdata_valid
);
  logic              rd_prev_q, rd_prev_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic              cap;

  always_comb begin
    ad_out    = send_add ? cur_addr : wbyte;
    ad_oe     = send_add | (send_data & wr_mode);
    cap       = cap_en & read_data & ~rd_prev_q & ~taken_q;
    rd_prev_d = read_data;
    // cs high marks the gap between transactions and re-arms the capture
    taken_d   = cs ? 1'b0 : (taken_q | cap);
    rdata_d   = cap ? ad_in : rdata_q;
    rvld_d    = cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_prev_q <= 1'b0;
      taken_q   <= 1'b0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      rd_prev_q <= rd_prev_d;
      taken_q   <= taken_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
endmodule

// File: rtl/rtc_access_sequencer.sv
// Splits a register burst into single FSM_W_R bus cycles, one register each.
// Optional per-phase watchdog: define RTC_ACCESS_TIMEOUT_EN.
module rtc_access_sequencer
  import rtc_pkg::*;
#(
  parameter int ADDR_W      = RTC_ADDR_W,
  parameter int CNT_W       = RTC_CNT_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] wdata,
  output logic [CNT_W-1:0]  wdata_idx,
  output logic [ADDR_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  rtc_access_sequencer_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wbyte_q, wbyte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic              wr_mode_q, wr_mode_d, do_it_q, do_it_d, w_r_q, w_r_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              cap_en;

`ifdef RTC_ACCESS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            waiting, timeout;
  assign waiting = (state_q == ST_ISSUE) || (state_q == ST_ACTIVE);
  assign timeout = waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;
`else
  // no watchdog: err can never assert
  assign err = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wbyte_d   = wbyte_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_mode_d = wr_mode_q;
    do_it_d   = do_it_q;
    w_r_d     = w_r_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef RTC_ACCESS_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      // done_q blocks a start landing on the done pulse cycle
      ST_IDLE: if (start && !done_q) begin
        wr_mode_d = wr_mode;
        w_r_d     = wr_mode;
        addr_d    = base_addr;
        cnt_d     = count;
        idx_d     = '0;
        busy_d    = 1'b1;
`ifdef RTC_ACCESS_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        if (count == '0) state_d = ST_DONE;
        else begin
          state_d = ST_ISSUE;
          do_it_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (wr_mode_q) wbyte_d = wdata;
        // drop do_it on acceptance so FSM_W_R cannot chain a second cycle
        if (!bus.fsm_cs) begin
          state_d = ST_ACTIVE;
          do_it_d = 1'b0;
        end
      end
      ST_ACTIVE: if (bus.fsm_cs) state_d = ST_NEXT;
      ST_NEXT: begin
        addr_d = addr_q + ADDR_W'(1);
        idx_d  = idx_q + CNT_W'(1);
        if (idx_q + CNT_W'(1) == cnt_q) state_d = ST_DONE;
        else begin
          state_d = ST_ISSUE;
          do_it_d = 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        w_r_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RTC_ACCESS_TIMEOUT_EN
    if (timeout) begin
      state_d = ST_DONE;
      do_it_d = 1'b0;
      err_d   = 1'b1;
    end
    wd_d = (state_d != state_q) ? '0 : (waiting ? wd_q + WD_W'(1) : wd_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wbyte_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_mode_q <= 1'b0;
      do_it_q   <= 1'b0;
      w_r_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wbyte_q   <= wbyte_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_mode_q <= wr_mode_d;
      do_it_q   <= do_it_d;
      w_r_q     <= w_r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef RTC_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  assign cap_en        = (state_q == ST_ACTIVE) && !wr_mode_q;
  assign bus.fsm_do_it = do_it_q;
  assign bus.fsm_w_r   = w_r_q;
  assign wdata_idx     = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;

  rtc_ad_bus_mux #(.ADDR_W(ADDR_W)) u_ad_mux (
    .clk         (clk),
    .reset       (reset),
    .cur_addr    (addr_q),
    .wbyte       (wbyte_q),
    .wr_mode     (wr_mode_q),
    .send_add    (bus.fsm_send_add),
    .send_data   (bus.fsm_send_data),
    .read_data   (bus.fsm_read_data),
    .cs          (bus.fsm_cs),
    .cap_en      (cap_en),
    .ad_in       (bus.ad_in),
    .ad_out      (bus.ad_out),
    .ad_oe       (bus.ad_oe),
    .rdata       (rdata),
    .rdata_valid (rdata_valid)
  );
endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Scoreboard bench for rtc_access_sequencer with a behavioural FSM_W_R model.
module tb_rtc_access_sequencer;
  import rtc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       wr_mode = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [3:0] count = 4'h0;
  logic [7:0] wdata;
  logic [3:0] wdata_idx;
  logic [7:0] rdata;
  logic       rdata_valid, busy, done, err;

  rtc_access_sequencer_if #(.ADDR_W(8)) bus_if ();

  rtc_access_sequencer #(.ADDR_W(8), .CNT_W(4), .TIMEOUT_CYC(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .wr_mode     (wr_mode),
    .base_addr   (base_addr),
    .count       (count),
    .wdata       (wdata),
    .wdata_idx   (wdata_idx),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write byte for the current index is 0x10 + idx
  always_comb wdata = 8'h10 + {4'h0, wdata_idx};

  typedef enum {K_ADDR, K_WDATA, K_RPHASE, K_RDATA, K_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] val;
  } ev_t;

  ev_t        sb_q[$];
  logic [7:0] rd_vals[$];
  int         total = 0;
  int         bad = 0;
  int         cs_falls = 0;
  int         done_cnt = 0;
  int         do_it_cnt = 0;
  bit         hang = 1'b0;
  logic       m_wr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  task automatic push_ev(input kind_e k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input kind_e k, input logic [15:0] got);
    ev_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_%s: got %h required no event", k.name(), got);
      return;
    end
    e = sb_q.pop_front();
    if (e.kind != k || e.val !== got) begin
      bad++;
      $display("FAIL sb_%s: got %h required %s %h", k.name(), got, e.kind.name(), e.val);
    end
  endtask

  // expected bus events for a burst; read bytes come from rd_vals
  task automatic push_burst(input bit wr, input logic [7:0] base, input int n, input bit e_err);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      push_ev(K_ADDR, {7'd0, 1'b1, a});
      if (wr) push_ev(K_WDATA, {7'd0, 1'b1, 8'h10 + 8'(i)});
      else begin
        push_ev(K_RPHASE, 16'h0000);
        push_ev(K_RDATA, {4'd0, 4'(i), rd_vals[i]});
      end
    end
    push_ev(K_DONE, {14'd0, 1'b0, e_err});
  endtask

  task automatic pulse_start(input bit wr, input logic [7:0] base, input logic [3:0] n,
                             output int at);
    @(posedge clk); #1;
    start = 1'b1; wr_mode = wr; base_addr = base; count = n;
    at = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL done_wait: got no done required done within %0d cycles", budget);
    end
  endtask

  task automatic wait_cs(input int target, input int budget);
    int k;
    k = 0;
    while (cs_falls < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("cs_wait", 32'(cs_falls >= target), 32'd1);
  endtask

  task automatic model_idle();
    bus_if.fsm_cs        = 1'b1;
    bus_if.fsm_send_add  = 1'b0;
    bus_if.fsm_send_data = 1'b0;
    bus_if.fsm_read_data = 1'b0;
  endtask

  // FSM_W_R model: cs low 2 cycles after do_it, 3 address cycles, 3 data cycles
  initial begin
    model_idle();
    bus_if.ad_in = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (bus_if.fsm_do_it && !reset && !hang) begin
        m_wr = bus_if.fsm_w_r;
        for (int s = 1; s <= 8; s++) begin
          @(posedge clk); #2;
          if (reset) begin
            model_idle();
            break;
          end
          if (s >= 2 && s <= 4) begin
            bus_if.fsm_cs       = 1'b0;
            bus_if.fsm_send_add = 1'b1;
          end else if (s >= 5 && s <= 7) begin
            bus_if.fsm_send_add  = 1'b0;
            bus_if.fsm_send_data = m_wr;
            bus_if.fsm_read_data = !m_wr;
            if (s == 5 && !m_wr)
              bus_if.ad_in = (rd_vals.size() > 0) ? rd_vals.pop_front() : 8'h00;
          end else if (s == 8) begin
            model_idle();
          end
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a bus event
  initial begin
    logic p_cs, p_sa, p_sd, p_rd;
    p_cs = 1'b1; p_sa = 1'b0; p_sd = 1'b0; p_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus_if.fsm_cs && p_cs) cs_falls++;
      if (bus_if.fsm_do_it) do_it_cnt++;
      if (bus_if.fsm_send_add && !p_sa)
        sb_check(K_ADDR, {7'd0, bus_if.ad_oe, bus_if.ad_out});
      if (bus_if.fsm_send_data && !p_sd)
        sb_check(K_WDATA, {7'd0, bus_if.ad_oe, bus_if.ad_out});
      if (bus_if.fsm_read_data && !p_rd)
        sb_check(K_RPHASE, {15'd0, bus_if.ad_oe});
      if (rdata_valid)
        sb_check(K_RDATA, {4'd0, wdata_idx, rdata});
      if (done) begin
        done_cnt++;
        sb_check(K_DONE, {14'd0, busy, err});
      end
      p_cs = bus_if.fsm_cs;
      p_sa = bus_if.fsm_send_add;
      p_sd = bus_if.fsm_send_data;
      p_rd = bus_if.fsm_read_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, at, c0, d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do_it", 32'(bus_if.fsm_do_it), 0);
    chk("rst_w_r", 32'(bus_if.fsm_w_r), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rdata_valid), 0);
    chk("rst_idx", 32'(wdata_idx), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // write burst 0x21 x3
    c0 = cs_falls;
    push_burst(1'b1, 8'h21, 3, 1'b0);
    pulse_start(1'b1, 8'h21, 4'd3, s);
    @(negedge clk);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_w_r", 32'(bus_if.fsm_w_r), 1);
    wait_done(100, at);
    chk("wr_cs_windows", 32'(cs_falls - c0), 3);
    @(negedge clk);
    chk("wr_w_r_idle", 32'(bus_if.fsm_w_r), 0);

    // address wrap 0xFF -> 0x00
    push_burst(1'b1, 8'hFF, 2, 1'b0);
    pulse_start(1'b1, 8'hFF, 4'd2, s);
    wait_done(100, at);

    // empty burst
    d0 = do_it_cnt;
    push_ev(K_DONE, 16'h0000);
    pulse_start(1'b0, 8'h33, 4'd0, s);
    wait_done(10, at);
    chk("empty_latency", 32'(at - s), 2);
    chk("empty_no_do_it", 32'(do_it_cnt - d0), 0);

    // reset during the second transaction of a 4-register burst
    c0 = cs_falls;
    push_burst(1'b1, 8'h30, 4, 1'b0);
    pulse_start(1'b1, 8'h30, 4'd4, s);
    wait_cs(c0 + 2, 100);
    @(posedge clk); #1;
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("midrst_do_it", 32'(bus_if.fsm_do_it), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_idx", 32'(wdata_idx), 0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 0);

    // read burst after reset
    c0 = cs_falls;
    rd_vals.push_back(8'hA5);
    rd_vals.push_back(8'h3C);
    push_burst(1'b0, 8'h41, 2, 1'b0);
    pulse_start(1'b0, 8'h41, 4'd2, s);
    wait_done(100, at);
    chk("rd_cs_windows", 32'(cs_falls - c0), 2);

    // start while busy must be ignored
    c0 = cs_falls;
    push_burst(1'b1, 8'h50, 3, 1'b0);
    pulse_start(1'b1, 8'h50, 4'd3, s);
    wait_cs(c0 + 1, 50);
    pulse_start(1'b0, 8'h99, 4'd5, at);
    wait_done(100, at);
    chk("busy_start_windows", 32'(cs_falls - c0), 3);
    repeat (15) @(negedge clk);
    chk("busy_start_no_extra", 32'(cs_falls - c0), 3);

`ifdef RTC_ACCESS_TIMEOUT_EN
    hang = 1'b1;
    push_ev(K_DONE, 16'h0001);
    pulse_start(1'b1, 8'h10, 4'd3, s);
    wait_done(60, at);
    chk("to_latency", 32'(at - s), 22);
    chk("to_do_it", 32'(bus_if.fsm_do_it), 0);
    chk("to_err", 32'(err), 1);
    hang = 1'b0;
    push_ev(K_DONE, 16'h0000);
    pulse_start(1'b0, 8'h00, 4'd0, s);
    @(negedge clk);
    chk("to_err_clear", 32'(err), 0);
    wait_done(10, at);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_access_sequencer.md
Name: rtc_access_sequencer

Overview:
- Upstream command stage for the FSM_W_R bus-cycle state machine.
- Converts a burst request into a series of single-register FSM_W_R transactions, for example "read 7 RTC registers starting at 0x21".
- Each transaction moves one register of the multiplexed address/data (A/D) bus.
- Drives the do_it and w_r inputs of FSM_W_R, muxes address or write data onto the A/D bus, and captures read bytes.
- Sits between the clock/time-keeping control logic and FSM_W_R.

Parameters:
- ADDR_W, 8, A/D bus and register address width.
- CNT_W, 4, burst-length field width; maximum burst is 2^CNT_W-1 registers.
- TIMEOUT_CYC, 255, maximum cycles spent waiting in a single phase. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- wr_mode  in  1  1 = write burst, 0 = read burst; captured on start.
- base_addr  in  ADDR_W  first register address; captured on start.
- count  in  CNT_W  number of registers in the burst; captured on start.
- wdata  in  ADDR_W  write byte for index wdata_idx; sampled in ISSUE.
- wdata_idx  out  CNT_W  index of the current register within the burst.
- rdata  out  ADDR_W  captured read byte.
- rdata_valid  out  1  one-cycle pulse; rdata and wdata_idx are valid while it is high.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  timeout flag; sticky until the next start.
- fsm_do_it  out  1  drives FSM_W_R do_it.
- fsm_w_r  out  1  drives FSM_W_R w_r (1 = write).
- fsm_cs  in  1  FSM_W_R cs, active-low.
- fsm_send_add  in  1  FSM_W_R send_add.
- fsm_send_data  in  1  FSM_W_R send_data.
- fsm_read_data  in  1  FSM_W_R read_data.
- ad_in  in  ADDR_W  A/D bus input from the pad.
- ad_out  out  ADDR_W  A/D bus output to the pad.
- ad_oe  out  1  pad output enable.

Behaviour:
- Reset:
  - State = IDLE.
  - fsm_do_it, busy, done, rdata_valid and err = 0.
  - rdata = 0, wdata_idx = 0, internal address = 0.
  - fsm_w_r = 0.
- Reset mid-burst: abort immediately and return to IDLE with the reset values above, dropping do_it the same cycle. No done pulse is issued.
- IDLE:
  - On start, latch wr_mode, base_addr and count.
  - Clear err and the index.
  - Go to DONE if count == 0 (no bus transaction); otherwise go to ISSUE.
  - start is ignored outside IDLE.
- ISSUE:
  - Latch wdata into the write-byte register when wr_mode = 1.
  - fsm_w_r = wr_mode.
  - fsm_do_it = 1, registered.
  - Stay in ISSUE until fsm_cs == 0 (transaction accepted), then go to ACTIVE with do_it = 0 that same cycle.
  - Dropping do_it here is what prevents FSM_W_R from starting an unintended back-to-back cycle.
- ACTIVE:
  - Wait for fsm_cs to return to 1, then go to NEXT.
  - Read capture: on the first cycle of fsm_read_data high, register ad_in into rdata and pulse rdata_valid on the following cycle.
  - At most one capture per transaction.
- NEXT:
  - Increment the address, wrapping modulo 2^ADDR_W (0xFF + 1 = 0x00).
  - Increment the index.
  - Go to DONE if index+1 == count; otherwise return to ISSUE.
  - Inter-transaction gap is 1 cycle.
- DONE: pulse done for 1 cycle, drop busy, go to IDLE. A start on the same cycle as the done pulse is ignored.
- A/D bus mux (combinational, from registered sources):
  - ad_out = fsm_send_add ? cur_addr : wbyte.
  - ad_oe = fsm_send_add | (fsm_send_data & wr_mode_q).
  - Read bursts never drive the data phase.
  - When both send strobes are high, address takes priority.
- fsm_w_r holds its value through the burst and is 0 in IDLE.

Optional Feature:
- Macro: RTC_ACCESS_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every state entry and counts while in ISSUE or ACTIVE.
  - When it reaches TIMEOUT_CYC: drop do_it, set err = 1, abort to DONE (done pulses), skip the remaining registers.
- Undefined:
  - No counter is generated; ISSUE and ACTIVE wait indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package rtc_pkg:
  - State encoding localparams: ST_IDLE, ST_ISSUE, ST_ACTIVE, ST_NEXT, ST_DONE.
  - Default ADDR_W and CNT_W.
  - RTC register address constants shared with the time-keeping logic.
- Natural sub-module: rtc_ad_bus_mux (the ad_out/ad_oe mux plus the read-capture edge detector).
- The sequencer itself stays a single module.

Test Plan:
- Bench instantiates a behavioural FSM_W_R model: cs falls 2 cycles after do_it, send_add for 3 cycles, then send_data or read_data for 3 cycles, cs rises.
- Write burst: start, wr_mode=1, base_addr=0x21, count=3, wdata = 0x10+idx.
  - Exactly 3 cs-low windows.
  - ad_out reads 0x21/0x10, 0x22/0x11, 0x23/0x12 with ad_oe high during both phases.
  - done after the third cs rise; busy low the same cycle.
- Read burst: wr_mode=0, base_addr=0x41, count=2, ad_in = 0xA5 then 0x3C during read_data.
  - Two rdata_valid pulses carrying 0xA5 (idx 0) and 0x3C (idx 1).
  - ad_oe = 0 during the data phase.
- Wrap and empty bursts:
  - base_addr=0xFF, count=2: second address is 0x00.
  - count=0: done 2 cycles after start, no do_it.
- Reset mid-burst: assert reset during the second ACTIVE of a 4-register burst.
  - Next cycle: do_it=0, busy=0, no done pulse.
  - A subsequent start works normally.
- Timeout (RTC_ACCESS_TIMEOUT_EN, TIMEOUT_CYC=20): model never lowers cs.
  - do_it drops, err=1 and done pulses at 20 cycles in ISSUE.
  - err clears on the next start.
- Start while busy: pulse start mid-burst with different arguments; the burst is unaffected and its original count is completed.
